// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline sequencing control.
//   ctrl_state_t : hazard controller state
//   pipe_ctrl_t  : bundle of pipeline-register control lines
//   MEMREAD_NONE : MemRead encoding for a non-load instruction
//   REG_ZERO     : hardwired-zero register index
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        HALT       = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] MEMREAD_NONE = 2'b00;
    localparam logic [4:0] REG_ZERO     = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_hold;
        logic exmem_hold;
    } pipe_ctrl_t;

    // Canonical control bundles
    localparam pipe_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                            idex_bubble: 1'b0, idex_hold: 1'b0, exmem_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                            idex_bubble: 1'b0, idex_hold: 1'b1, exmem_hold: 1'b1};
    localparam pipe_ctrl_t CTRL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                            idex_bubble: 1'b1, idex_hold: 1'b0, exmem_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_BRANCH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                            idex_bubble: 1'b1, idex_hold: 1'b0, exmem_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_LOADUSE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                            idex_bubble: 1'b1, idex_hold: 1'b0, exmem_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_JUMP    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                            idex_bubble: 1'b0, idex_hold: 1'b0, exmem_hold: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector.
//   ex_mem_read, ex_write_reg : load indication and destination of the EX instruction
//   id_rs, id_rt, id_uses_rt  : source operands of the ID instruction
//   load_use                  : ID instruction needs a value the EX load has not produced yet
module hazard_detect
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] ex_mem_read,
    input  logic [4:0] ex_write_reg,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    // $0 is never a real dependency; rt only matters when it is a source
    assign load_use = (ex_mem_read != MEMREAD_NONE) &&
                      (ex_write_reg != REG_ZERO) &&
                      ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Drives PC / IF/ID / ID/EX / EX/MEM write, flush, bubble and hold controls:
// one bubble per load-use hazard, squash on jump / taken branch, freeze while
// data memory is busy, sticky timeout error if memory never answers.
//   clk, rst                       : clock, synchronous active-high reset
//   ex_mem_read, ex_write_reg      : EX-stage load info
//   id_rs, id_rt, id_uses_rt       : ID-stage sources
//   branch_taken, jump_id          : control-flow redirects
//   mem_req, mem_ready             : data-memory handshake
//   pc_write .. exmem_hold         : combinational pipeline controls
//   stall_count, flush_count       : saturating performance counters
//   mem_timeout                    : sticky memory-timeout error
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MAX_MEM_WAIT = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int unsigned WAIT_W = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT - 1);

    ctrl_state_t       state;
    ctrl_state_t       next_state;
    pipe_ctrl_t        ctrl;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_stall;
    logic              run_eval;
    logic              lu_en;
    logic              timeout_hit;

    hazard_detect u_hazard_detect (
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .load_use     (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    // Next state and zero-latency pipeline controls
    always_comb begin
        ctrl        = CTRL_DEFAULT;
        next_state  = state;
        run_eval    = 1'b0;
        lu_en       = 1'b0;
        timeout_hit = 1'b0;

        case (state)
            RUN, LOAD_STALL: begin
                if (mem_stall) begin
                    ctrl       = CTRL_FREEZE;
                    next_state = MEM_WAIT;
                end else begin
                    run_eval = 1'b1;
                    // The hazard already paid its bubble once we are in LOAD_STALL
                    lu_en    = (state == RUN);
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    ctrl = CTRL_FREEZE;
                    // >= keeps MAX_MEM_WAIT=1 working: entry already set the counter to 1
                    if (wait_cnt >= WAIT_LIMIT) begin
                        next_state  = HALT;
                        timeout_hit = 1'b1;
                    end
                end else begin
                    run_eval = 1'b1;
                    lu_en    = 1'b1;
                end
            end
            default: begin
                ctrl = CTRL_FREEZE;
            end
        endcase

        // Shared priority evaluation for the non-stalled case
        if (run_eval) begin
            if (branch_taken) begin
                ctrl       = CTRL_BRANCH;
                next_state = RUN;
            end else if (lu_en && load_use) begin
                ctrl       = CTRL_LOADUSE;
                next_state = LOAD_STALL;
            end else if (jump_id) begin
                ctrl       = CTRL_JUMP;
                next_state = RUN;
            end else begin
                next_state = RUN;
            end
        end

        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign idex_hold   = ctrl.idex_hold;
    assign exmem_hold  = ctrl.exmem_hold;

    // State, wait counter, performance counters and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= next_state;

            if ((state != MEM_WAIT) && (next_state == MEM_WAIT)) begin
                wait_cnt <= WAIT_W'(1);
            end else if ((state == MEM_WAIT) && !mem_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (!ctrl.pc_write && !(&stall_count)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (ctrl.ifid_flush && !(&flush_count)) begin
                flush_count <= flush_count + CNT_W'(1);
            end

            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ex_mem_read = 2'b00;
    logic [4:0] ex_write_reg = 5'd0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       id_uses_rt = 1'b0;
    logic       branch_taken = 1'b0;
    logic       jump_id = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold;
    logic [3:0] stall_count, flush_count;
    logic       mem_timeout;

    logic       b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_idex_hold, b_exmem_hold;
    logic [3:0] b_stall_count, b_flush_count;
    logic       b_mem_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected control patterns {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold}
    localparam logic [5:0] E_DEF    = 6'b110000;
    localparam logic [5:0] E_FREEZE = 6'b000011;
    localparam logic [5:0] E_RESET  = 6'b001100;
    localparam logic [5:0] E_BRANCH = 6'b111100;
    localparam logic [5:0] E_LU     = 6'b000100;
    localparam logic [5:0] E_JUMP   = 6'b111000;

    pipeline_hazard_ctrl #(.MAX_MEM_WAIT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .stall_count(stall_count), .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    // Minimum-timeout instance sharing the same stimulus
    pipeline_hazard_ctrl #(.MAX_MEM_WAIT(1), .CNT_W(4)) dut_min (
        .clk(clk), .rst(rst),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .idex_hold(b_idex_hold), .exmem_hold(b_exmem_hold),
        .stall_count(b_stall_count), .flush_count(b_flush_count), .mem_timeout(b_mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        #1;
        check(tag, 32'({pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold}),
              32'(exp));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ex_mem_read  = 2'b00;
        ex_write_reg = 5'd0;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        id_uses_rt   = 1'b0;
        branch_taken = 1'b0;
        jump_id      = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset behaviour
        clear_inputs();
        check_ctrl("reset_ctrl", E_RESET);
        tick();
        tick();
        check("reset_stall", 32'(stall_count), 32'd0);
        check("reset_flush", 32'(flush_count), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        rst = 1'b0;
        check_ctrl("run_default", E_DEF);

        // Load-use via rs: exactly one bubble even if condition persists
        ex_mem_read = 2'b01; ex_write_reg = 5'd5; id_rs = 5'd5;
        check_ctrl("lu_rs_bubble", E_LU);
        tick();
        check_ctrl("lu_masked_in_stall", E_DEF);
        tick();
        check("lu_stall_count", 32'(stall_count), 32'd1);
        clear_inputs();

        // Non-hazards: $0 destination, rt not used as source; then rt used
        ex_mem_read = 2'b10; ex_write_reg = 5'd0; id_rs = 5'd0;
        check_ctrl("lu_reg0_none", E_DEF);
        ex_write_reg = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        check_ctrl("lu_rt_unused_none", E_DEF);
        id_uses_rt = 1'b1;
        check_ctrl("lu_rt_used", E_LU);
        tick();
        clear_inputs();
        tick();
        check("lu_rt_stall_count", 32'(stall_count), 32'd2);

        // Taken branch outranks load-use
        do_reset();
        ex_mem_read = 2'b01; ex_write_reg = 5'd5; id_rs = 5'd5; branch_taken = 1'b1;
        check_ctrl("branch_over_lu", E_BRANCH);
        tick();
        check("branch_flush_count", 32'(flush_count), 32'd1);
        check("branch_stall_count", 32'(stall_count), 32'd0);
        branch_taken = 1'b0;
        check_ctrl("branch_next_is_run", E_LU);
        clear_inputs();

        // Zero-wait memory, then 3-cycle memory stall
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b1;
        check_ctrl("mem_zero_wait", E_DEF);
        mem_ready = 1'b0;
        check_ctrl("mem_freeze_1", E_FREEZE);
        tick();
        check("min_timeout_not_yet", 32'(b_mem_timeout), 32'd0);
        check_ctrl("mem_freeze_2", E_FREEZE);
        tick();
        check("min_timeout_set", 32'(b_mem_timeout), 32'd1);
        check_ctrl("mem_freeze_3", E_FREEZE);
        tick();
        mem_ready = 1'b1;
        check_ctrl("mem_release", E_DEF);
        check("min_halt_frozen", 32'(b_pc_write), 32'd0);
        tick();
        check("mem3_stall_count", 32'(stall_count), 32'd3);
        check("mem3_timeout", 32'(mem_timeout), 32'd0);

        // mem_ready in the would-be timeout cycle wins
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (14) tick();
        mem_ready = 1'b1;
        check_ctrl("late_ready_release", E_DEF);
        tick();
        check("late_ready_no_timeout", 32'(mem_timeout), 32'd0);

        // Memory never answers: HALT after 15 frozen cycles
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (14) tick();
        check("timeout_before", 32'(mem_timeout), 32'd0);
        check_ctrl("timeout_last_freeze", E_FREEZE);
        tick();
        check("timeout_set", 32'(mem_timeout), 32'd1);
        check("timeout_stall_count", 32'(stall_count), 32'd15);
        mem_req = 1'b0; mem_ready = 1'b1;
        check_ctrl("halt_frozen", E_FREEZE);
        repeat (3) tick();
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        check("halt_stall_saturated", 32'(stall_count), 32'd15);
        do_reset();
        check("post_reset_timeout", 32'(mem_timeout), 32'd0);
        check("post_reset_stall", 32'(stall_count), 32'd0);
        check_ctrl("post_reset_run", E_DEF);

        // Continuous jumps saturate the flush counter
        jump_id = 1'b1;
        check_ctrl("jump_flush", E_JUMP);
        repeat (14) tick();
        check("flush_count_14", 32'(flush_count), 32'd14);
        repeat (6) tick();
        check("flush_count_sat", 32'(flush_count), 32'd15);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
